// File: rtl/grid_move_ctrl.sv
// Grid movement controller: owns the player position, paces each step with a
// down-counting timer and reports accepted, finished and refused moves.
module grid_move_ctrl #(
  parameter int MAP_WIDTH   = 8,
  parameter int MAP_HEIGHT  = 8,
  parameter int START_X     = 0,
  parameter int START_Y     = 0,
  parameter int MOVE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [3:0] key_dir,
  input  logic [3:0] allow,
  output logic [3:0] pos_x,
  output logic [3:0] pos_y,
  output logic [3:0] move_dir,
  output logic       moving,
  output logic       move_done,
  output logic       blocked,
  output logic [7:0] step_count
);

  // state   | meaning
  // IDLE    | waiting for a single-direction request
  // MOVE    | step in progress, timer counts down to 0
  // BLOCKED | request refused, waiting for key_dir to change
  typedef enum logic [1:0] {IDLE, MOVE, BLOCKED} state_t;

  localparam logic [3:0]  X_MAX  = 4'(MAP_WIDTH - 1);
  localparam logic [3:0]  Y_MAX  = 4'(MAP_HEIGHT - 1);
  localparam logic [15:0] T_LOAD = 16'(MOVE_CYCLES - 1);

  state_t      state, state_nxt;
  logic [15:0] timer, timer_nxt;
  logic [3:0]  latched_dir, latched_dir_nxt;
  logic [3:0]  pos_x_nxt, pos_y_nxt, move_dir_nxt;
  logic        moving_nxt, move_done_nxt, blocked_nxt;
  logic [7:0]  step_count_nxt;
  logic        req_valid, in_range, permitted;

  assign req_valid = en && $onehot(key_dir);

  // Defensive map-edge check on top of the external allow mask
  always_comb begin
    in_range = 1'b0;
    case (key_dir)
      4'b1000: in_range = (pos_x < X_MAX);
      4'b0100: in_range = (pos_y != 4'd0);
      4'b0010: in_range = (pos_y < Y_MAX);
      4'b0001: in_range = (pos_x != 4'd0);
      default: in_range = 1'b0;
    endcase
  end

  assign permitted = (|(key_dir & allow)) && in_range;

  always_comb begin
    state_nxt       = state;
    timer_nxt       = timer;
    latched_dir_nxt = latched_dir;
    pos_x_nxt       = pos_x;
    pos_y_nxt       = pos_y;
    move_dir_nxt    = move_dir;
    moving_nxt      = moving;
    move_done_nxt   = 1'b0;
    blocked_nxt     = 1'b0;
    step_count_nxt  = step_count;
    case (state)
      IDLE: begin
        if (req_valid) begin
          if (permitted) begin
            case (key_dir)
              4'b1000: pos_x_nxt = pos_x + 4'd1;
              4'b0001: pos_x_nxt = pos_x - 4'd1;
              4'b0010: pos_y_nxt = pos_y + 4'd1;
              default: pos_y_nxt = pos_y - 4'd1;
            endcase
            move_dir_nxt = key_dir;
            moving_nxt   = 1'b1;
            timer_nxt    = T_LOAD;
            if (step_count != 8'hFF) step_count_nxt = step_count + 8'd1;
            state_nxt    = MOVE;
          end else begin
            blocked_nxt     = 1'b1;
            latched_dir_nxt = key_dir;
            state_nxt       = BLOCKED;
          end
        end
      end
      MOVE: begin
        if (timer != 16'd0) begin
          timer_nxt = timer - 16'd1;
        end else begin
          moving_nxt    = 1'b0;
          move_dir_nxt  = 4'd0;
          move_done_nxt = 1'b1;
          state_nxt     = IDLE;
        end
      end
      BLOCKED: begin
        if (key_dir != latched_dir) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      timer       <= 16'd0;
      latched_dir <= 4'd0;
      pos_x       <= 4'(START_X);
      pos_y       <= 4'(START_Y);
      move_dir    <= 4'd0;
      moving      <= 1'b0;
      move_done   <= 1'b0;
      blocked     <= 1'b0;
      step_count  <= 8'd0;
    end else begin
      state       <= state_nxt;
      timer       <= timer_nxt;
      latched_dir <= latched_dir_nxt;
      pos_x       <= pos_x_nxt;
      pos_y       <= pos_y_nxt;
      move_dir    <= move_dir_nxt;
      moving      <= moving_nxt;
      move_done   <= move_done_nxt;
      blocked     <= blocked_nxt;
      step_count  <= step_count_nxt;
    end
  end

endmodule

// File: tb/tb_grid_move_ctrl.sv
// Bench for grid_move_ctrl: two instances (4-cycle and 1-cycle steps) driven
// with directed and random stimulus and compared every cycle to a step model.
module tb_grid_move_ctrl;

  localparam int W = 8;
  localparam int H = 8;

  logic       clk = 1'b0;
  logic [1:0] rst, en;
  logic [3:0] key [2];
  logic [3:0] allow [2];
  logic [3:0] pos_x [2], pos_y [2], move_dir [2];
  logic [1:0] moving, move_done, blocked;
  logic [7:0] step_count [2];

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  grid_move_ctrl #(.MAP_WIDTH(W), .MAP_HEIGHT(H), .START_X(0), .START_Y(0),
                   .MOVE_CYCLES(4)) u0 (
    .clk(clk), .rst(rst[0]), .en(en[0]), .key_dir(key[0]), .allow(allow[0]),
    .pos_x(pos_x[0]), .pos_y(pos_y[0]), .move_dir(move_dir[0]),
    .moving(moving[0]), .move_done(move_done[0]), .blocked(blocked[0]),
    .step_count(step_count[0]));

  grid_move_ctrl #(.MAP_WIDTH(W), .MAP_HEIGHT(H), .START_X(0), .START_Y(0),
                   .MOVE_CYCLES(1)) u1 (
    .clk(clk), .rst(rst[1]), .en(en[1]), .key_dir(key[1]), .allow(allow[1]),
    .pos_x(pos_x[1]), .pos_y(pos_y[1]), .move_dir(move_dir[1]),
    .moving(moving[1]), .move_done(move_done[1]), .blocked(blocked[1]),
    .step_count(step_count[1]));

  // rem = cycles of the current step still to run; hold = refused key still held
  typedef struct packed {
    int         px;
    int         py;
    int         cnt;
    int         rem;
    logic       hold;
    logic [3:0] held;
    logic       done;
    logic       blk;
    logic [3:0] dir;
  } mdl_t;

  mdl_t m [2];
  int   mc [2] = '{4, 1};

  function automatic logic [3:0] bound_allow(int px, int py);
    return {px < W - 1, py > 0, py < H - 1, px > 0};
  endfunction

  function automatic mdl_t mstep(mdl_t s, int cyc_per_step, logic r, logic e,
                                 logic [3:0] k, logic [3:0] a);
    mdl_t n = s;
    int nx, ny;
    n.done = 1'b0;
    n.blk  = 1'b0;
    if (r) begin
      n.px = 0; n.py = 0; n.cnt = 0; n.rem = 0;
      n.hold = 1'b0; n.held = 4'd0; n.dir = 4'd0;
    end else if (s.rem > 0) begin
      n.rem = s.rem - 1;
      if (n.rem == 0) begin
        n.done = 1'b1;
        n.dir  = 4'd0;
      end
    end else if (s.hold) begin
      if (k != s.held) n.hold = 1'b0;
    end else if (e && $countones(k) == 1) begin
      nx = s.px;
      ny = s.py;
      if (k[3]) nx = nx + 1;
      if (k[0]) nx = nx - 1;
      if (k[1]) ny = ny + 1;
      if (k[2]) ny = ny - 1;
      if ((a & k) != 4'd0 && nx >= 0 && nx < W && ny >= 0 && ny < H) begin
        n.px  = nx;
        n.py  = ny;
        n.rem = cyc_per_step;
        n.dir = k;
        n.cnt = (s.cnt < 255) ? s.cnt + 1 : 255;
      end else begin
        n.blk  = 1'b1;
        n.hold = 1'b1;
        n.held = k;
      end
    end
    return n;
  endfunction

  task automatic chk(string tag, int act, int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic check_inst(int i, int cyc);
    string p;
    p = $sformatf("u%0d c%0d", i, cyc);
    chk({p, " pos_x"},      int'(pos_x[i]),      m[i].px);
    chk({p, " pos_y"},      int'(pos_y[i]),      m[i].py);
    chk({p, " move_dir"},   int'(move_dir[i]),   int'(m[i].dir));
    chk({p, " moving"},     int'(moving[i]),     int'(m[i].rem > 0));
    chk({p, " move_done"},  int'(move_done[i]),  int'(m[i].done));
    chk({p, " blocked"},    int'(blocked[i]),    int'(m[i].blk));
    chk({p, " step_count"}, int'(step_count[i]), m[i].cnt);
  endtask

  task automatic drive(int cyc);
    int r, b;
    rst[1] = (cyc < 3);
    rst[0] = (cyc < 3) || (cyc >= 80 && $urandom_range(0, 99) == 0);

    // u0: walk right into the edge, release, en/multi-key no-ops, then random
    if (cyc < 60) begin
      en[0] = 1'b1; key[0] = 4'b1000; allow[0] = bound_allow(m[0].px, m[0].py);
    end else if (cyc < 70) begin
      en[0] = 1'b1; key[0] = 4'b0000; allow[0] = bound_allow(m[0].px, m[0].py);
    end else if (cyc < 75) begin
      en[0] = 1'b0; key[0] = 4'b0010; allow[0] = 4'b1111;
    end else if (cyc < 80) begin
      en[0] = 1'b1; key[0] = 4'b1001; allow[0] = 4'b1111;
    end else begin
      if ($urandom_range(0, 3) == 0) begin
        r = $urandom_range(0, 9);
        if (r == 0)      key[0] = 4'b0000;
        else if (r <= 6) key[0] = 4'(1 << $urandom_range(0, 3));
        else             key[0] = 4'($urandom_range(0, 15));
      end
      en[0]    = ($urandom_range(0, 7) != 0);
      allow[0] = ($urandom_range(0, 1) == 1) ? bound_allow(m[0].px, m[0].py)
                                             : 4'($urandom_range(0, 15));
    end

    // u1: always a permitted direction, for back-to-back steps and saturation
    en[1]    = 1'b1;
    allow[1] = bound_allow(m[1].px, m[1].py);
    b = $urandom_range(0, 3);
    for (int t = 0; t < 4 && !allow[1][b]; t++) b = (b + 1) % 4;
    key[1] = 4'(1 << b);
  endtask

  initial begin
    rst = 2'b11;
    en  = 2'b00;
    key[0] = 4'd0; key[1] = 4'd0;
    allow[0] = 4'd0; allow[1] = 4'd0;
    for (int i = 0; i < 2; i++)
      m[i] = mstep(m[i], mc[i], 1'b1, 1'b0, 4'd0, 4'd0);

    for (int cyc = 0; cyc < 1500; cyc++) begin
      @(negedge clk);
      drive(cyc);
      @(posedge clk);
      for (int i = 0; i < 2; i++)
        m[i] = mstep(m[i], mc[i], rst[i], en[i], key[i], allow[i]);
      #1;
      for (int i = 0; i < 2; i++) check_inst(i, cyc);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
